// File: rtl/warp_pkg.sv
// Shared constants for the warp fetch aligner: widths, decoder-select codes, fetch FSM states.
// Compressed-instruction support is compiled in with the WARP_RVC_EN macro.
package warp_pkg;

    localparam int unsigned PARCEL_W = 16;
    localparam int unsigned FETCH_W  = 64;

    localparam logic [1:0] BSEL_U0 = 2'd0;
    localparam logic [1:0] BSEL_U1 = 2'd1;
    localparam logic [1:0] BSEL_C0 = 2'd2;
    localparam logic [1:0] BSEL_C1 = 2'd3;

    localparam logic [1:0] ST_REQ     = 2'd0;
    localparam logic [1:0] ST_WAIT    = 2'd1;
    localparam logic [1:0] ST_DISCARD = 2'd2;

    // Low two bits of a parcel equal to 2'b11 mark the start of a 32-bit instruction.
    function automatic logic is_rvi(input logic [1:0] lsb);
        return lsb == 2'b11;
    endfunction

endpackage

// File: rtl/warp_parcel_fifo.sv
// Circular buffer of 16-bit parcels: up to 4 pushed and 0-4 popped per cycle,
// with the head 4 parcels exposed (zero where not present).
module warp_parcel_fifo
    import warp_pkg::*;
#(
    parameter int unsigned DEPTH = 8,
    localparam int unsigned PTR_W = $clog2(DEPTH),
    localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               flush,
    input  logic               push,
    input  logic [2:0]         push_n,
    input  logic [FETCH_W-1:0] push_data,
    input  logic [2:0]         pop_n,
    output logic [CNT_W-1:0]   count,
    output logic [FETCH_W-1:0] peek
);

    logic [PARCEL_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]    rd_ptr;
    logic [PTR_W-1:0]    wr_ptr;
    logic [2:0]          push_cnt;

    // Pointer advance with wrap; DEPTH need not be a power of two.
    function automatic logic [PTR_W-1:0] wrap(input logic [PTR_W-1:0] base, input logic [2:0] off);
        logic [PTR_W:0] sum;
        sum = {1'b0, base} + (PTR_W+1)'(off);
        if (sum >= (PTR_W+1)'(DEPTH)) begin
            sum = sum - (PTR_W+1)'(DEPTH);
        end
        return sum[PTR_W-1:0];
    endfunction

    assign push_cnt = push ? push_n : 3'd0;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= wrap(wr_ptr, push_cnt);
            rd_ptr <= wrap(rd_ptr, pop_n);
            count  <= count + CNT_W'(push_cnt) - CNT_W'(pop_n);
        end
    end

    always_ff @(posedge i_clk) begin
        for (int i = 0; i < 4; i++) begin
            if (3'(i) < push_cnt) begin
                mem[wrap(wr_ptr, 3'(i))] <= push_data[PARCEL_W*i +: PARCEL_W];
            end
        end
    end

    always_comb begin
        peek = '0;
        for (int i = 0; i < 4; i++) begin
            if (CNT_W'(i) < count) begin
                peek[PARCEL_W*i +: PARCEL_W] = mem[wrap(rd_ptr, 3'(i))];
            end
        end
    end

endmodule

// File: rtl/warp_fetch_align.sv
// Fetch buffer and two-slot instruction aligner feeding the IF/ID barrier.
// WARP_RVC_EN enables 16-bit compressed instructions and 2-byte-aligned redirects.
module warp_fetch_align
    import warp_pkg::*;
#(
    parameter logic [63:0] RESET_ADDR = 64'h0000000000000000,
    parameter int unsigned DEPTH      = 8
) (
    input  logic               i_clk,
    input  logic               i_rst,
    output logic               o_fetch_req,
    output logic [FETCH_W-1:0] o_fetch_addr,
    input  logic               i_fetch_gnt,
    input  logic               i_fetch_rvalid,
    input  logic [FETCH_W-1:0] i_fetch_rdata,
    input  logic               i_redirect,
    input  logic [63:0]        i_redirect_pc,
    input  logic               i_stall,
    output logic [1:0]         o_valid,
    output logic [31:0]        o_uinst0,
    output logic [31:0]        o_uinst1,
    output logic [15:0]        o_cinst0,
    output logic [15:0]        o_cinst1,
    output logic [1:0]         o_bsel0,
    output logic [1:0]         o_bsel1,
    output logic [63:0]        o_pc0,
    output logic [63:0]        o_pc1
);

    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

`ifdef WARP_RVC_EN
    localparam logic [63:0] RST_PC   = {RESET_ADDR[63:1], 1'b0};
    localparam logic [1:0]  RST_SKIP = RESET_ADDR[2:1];
`else
    localparam logic [63:0] RST_PC   = {RESET_ADDR[63:2], 2'b00};
    localparam logic [1:0]  RST_SKIP = 2'b00;
`endif

    logic [1:0]          state, state_d;
    logic [63:0]         fetch_addr, fetch_addr_d;
    logic [63:0]         head_pc, head_pc_d;
    logic [1:0]          skip, skip_d;
    logic                push;
    logic [2:0]          push_n;
    logic [FETCH_W-1:0]  push_data;
    logic [2:0]          pop_n;
    logic [CNT_W-1:0]    count;
    logic [FETCH_W-1:0]  peek;
    logic [63:0]         redir_pc;
    logic [1:0]          redir_skip;
    logic [PARCEL_W-1:0] p [4];
    logic [PARCEL_W-1:0] s1_lo, s1_hi;
    logic [2:0]          avail, len0, len1;
    logic                v0, v1, v0g, v1g;
    logic                unused_pc_bits;

`ifdef WARP_RVC_EN
    assign redir_pc   = {i_redirect_pc[63:1], 1'b0};
    assign redir_skip = i_redirect_pc[2:1];
`else
    assign redir_pc   = {i_redirect_pc[63:2], 2'b00};
    assign redir_skip = 2'b00;
`endif
    assign unused_pc_bits = ^i_redirect_pc[1:0];

    assign o_fetch_addr = fetch_addr;
    // Request is gated so a full 4-parcel response always fits.
    assign o_fetch_req  = !i_rst && !i_redirect && (state == ST_REQ) && (count <= CNT_W'(DEPTH - 4));

    assign push_n    = 3'd4 - 3'(skip);
    assign push_data = i_fetch_rdata >> {skip, 4'b0000};

    warp_parcel_fifo #(.DEPTH(DEPTH)) u_fifo (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .flush     (i_redirect),
        .push      (push),
        .push_n    (push_n),
        .push_data (push_data),
        .pop_n     (pop_n),
        .count     (count),
        .peek      (peek)
    );

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state      <= ST_REQ;
            fetch_addr <= {RESET_ADDR[63:3], 3'b000};
            head_pc    <= RST_PC;
            skip       <= RST_SKIP;
        end else begin
            state      <= state_d;
            fetch_addr <= fetch_addr_d;
            head_pc    <= head_pc_d;
            skip       <= skip_d;
        end
    end

    // Fetch FSM; a redirect while a response is still owed parks in DISCARD.
    always_comb begin
        state_d      = state;
        fetch_addr_d = fetch_addr;
        skip_d       = skip;
        push         = 1'b0;
        if (i_redirect) begin
            fetch_addr_d = {redir_pc[63:3], 3'b000};
            skip_d       = redir_skip;
            state_d      = ((state == ST_WAIT || state == ST_DISCARD) && !i_fetch_rvalid) ? ST_DISCARD : ST_REQ;
        end else begin
            case (state)
                ST_REQ: begin
                    if (o_fetch_req && i_fetch_gnt) begin
                        state_d      = ST_WAIT;
                        fetch_addr_d = fetch_addr + 64'd8;
                    end
                end
                ST_WAIT: begin
                    if (i_fetch_rvalid) begin
                        push    = 1'b1;
                        skip_d  = 2'b00;
                        state_d = ST_REQ;
                    end
                end
                ST_DISCARD: begin
                    if (i_fetch_rvalid) begin
                        state_d = ST_REQ;
                    end
                end
                default: state_d = ST_REQ;
            endcase
        end
    end

    // Length detect and slot validity over the head parcels.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            p[i] = peek[PARCEL_W*i +: PARCEL_W];
        end
        avail = (count >= CNT_W'(4)) ? 3'd4 : 3'(count);
`ifdef WARP_RVC_EN
        len0  = is_rvi(p[0][1:0]) ? 3'd2 : 3'd1;
        s1_lo = (len0 == 3'd1) ? p[1] : p[2];
        s1_hi = (len0 == 3'd1) ? p[2] : p[3];
        len1  = is_rvi(s1_lo[1:0]) ? 3'd2 : 3'd1;
`else
        len0  = 3'd2;
        s1_lo = p[2];
        s1_hi = p[3];
        len1  = 3'd2;
`endif
        v0  = avail >= len0;
        v1  = v0 && (avail >= len0 + len1);
        v0g = v0 && !i_redirect;
        v1g = v1 && v0g;
    end

    always_comb begin
        o_valid  = {v1g, v0g};
        o_uinst0 = '0;
        o_uinst1 = '0;
        o_cinst0 = '0;
        o_cinst1 = '0;
        o_bsel0  = BSEL_U0;
        o_bsel1  = BSEL_U0;
        if (v0g) begin
            o_uinst0 = {p[1], p[0]};
            o_bsel0  = BSEL_U0;
`ifdef WARP_RVC_EN
            if (len0 == 3'd1) begin
                o_uinst0 = '0;
                o_cinst0 = p[0];
                o_bsel0  = BSEL_C0;
            end
`endif
        end
        if (v1g) begin
            o_uinst1 = {s1_hi, s1_lo};
            o_bsel1  = BSEL_U1;
`ifdef WARP_RVC_EN
            if (len1 == 3'd1) begin
                o_uinst1 = '0;
                o_cinst1 = s1_lo;
                o_bsel1  = BSEL_C1;
            end
`endif
        end
    end

    assign o_pc0     = head_pc;
    assign o_pc1     = head_pc + (v0 ? {60'b0, len0, 1'b0} : 64'd0);
    assign pop_n     = (i_stall || i_redirect) ? 3'd0
                     : (v0 ? len0 : 3'd0) + (v1 ? len1 : 3'd0);
    assign head_pc_d = i_redirect ? redir_pc : head_pc + {60'b0, pop_n, 1'b0};

endmodule

// File: tb/tb_warp_fetch_align.sv
// Scoreboard bench for warp_fetch_align: a memory responder feeds fetches, expected
// instructions are queued per test and a monitor checks each issued slot in order.
module tb_warp_fetch_align;
    import warp_pkg::*;

    logic        i_clk, i_rst;
    logic        o_fetch_req;
    logic [63:0] o_fetch_addr;
    logic        i_fetch_gnt, i_fetch_rvalid;
    logic [63:0] i_fetch_rdata;
    logic        i_redirect;
    logic [63:0] i_redirect_pc;
    logic        i_stall;
    logic [1:0]  o_valid;
    logic [31:0] o_uinst0, o_uinst1;
    logic [15:0] o_cinst0, o_cinst1;
    logic [1:0]  o_bsel0, o_bsel1;
    logic [63:0] o_pc0, o_pc1;

    warp_fetch_align #(.RESET_ADDR(64'h0), .DEPTH(8)) dut (
        .i_clk          (i_clk),
        .i_rst          (i_rst),
        .o_fetch_req    (o_fetch_req),
        .o_fetch_addr   (o_fetch_addr),
        .i_fetch_gnt    (i_fetch_gnt),
        .i_fetch_rvalid (i_fetch_rvalid),
        .i_fetch_rdata  (i_fetch_rdata),
        .i_redirect     (i_redirect),
        .i_redirect_pc  (i_redirect_pc),
        .i_stall        (i_stall),
        .o_valid        (o_valid),
        .o_uinst0       (o_uinst0),
        .o_uinst1       (o_uinst1),
        .o_cinst0       (o_cinst0),
        .o_cinst1       (o_cinst1),
        .o_bsel0        (o_bsel0),
        .o_bsel1        (o_bsel1),
        .o_pc0          (o_pc0),
        .o_pc1          (o_pc1)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    typedef struct {
        logic [63:0] pc;
        logic [31:0] inst;
        bit          c;
    } exp_t;

    exp_t        exp_q[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    logic [63:0] mem [64];
    int          budget = 0;
    int          lat    = 0;
    int          cnt    = 0;
    bit          pend   = 1'b0;
    logic [63:0] paddr  = 64'h0;
    logic [63:0] last_gnt = 64'h0;
    int          ngnt   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic exp_push(input logic [63:0] pc, input logic [31:0] inst, input bit c);
        exp_t e;
        e.pc = pc; e.inst = inst; e.c = c;
        exp_q.push_back(e);
    endtask

    task automatic check_slot(input int s);
        exp_t        e;
        logic [31:0] act_inst;
        logic [1:0]  act_bsel;
        logic [63:0] act_pc;
        act_bsel = (s == 0) ? o_bsel0 : o_bsel1;
        act_pc   = (s == 0) ? o_pc0 : o_pc1;
        if (s == 0) act_inst = act_bsel[1] ? {16'h0, o_cinst0} : o_uinst0;
        else        act_inst = act_bsel[1] ? {16'h0, o_cinst1} : o_uinst1;
        if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_slot%0d: got pc %h inst %h expected no instruction", s, act_pc, act_inst);
        end else begin
            e = exp_q.pop_front();
            chk($sformatf("slot%0d_pc", s), act_pc, e.pc);
            chk($sformatf("slot%0d_inst@%h", s, e.pc), 64'(act_inst), 64'(e.inst));
            chk($sformatf("slot%0d_bsel@%h", s, e.pc), 64'(act_bsel),
                64'(e.c ? (s == 0 ? BSEL_C0 : BSEL_C1) : (s == 0 ? BSEL_U0 : BSEL_U1)));
        end
    endtask

    // Monitor: every consumed slot is checked against the next expected instruction.
    initial begin
        forever begin
            @(negedge i_clk);
            #1;
            if (!i_rst && !i_stall && o_valid != 2'b00) begin
                if (o_valid == 2'b10) chk("slot1_without_slot0", 64'(o_valid), 64'd3);
                if (o_valid[0]) check_slot(0);
                if (o_valid[1]) check_slot(1);
            end
        end
    end

    // Memory responder: grants while budget remains, answers after lat idle cycles.
    task automatic mem_drive();
        i_fetch_gnt    = 1'b0;
        i_fetch_rvalid = 1'b0;
        i_fetch_rdata  = 64'h0;
        if (pend) begin
            if (cnt == 0) begin
                i_fetch_rvalid = 1'b1;
                i_fetch_rdata  = mem[paddr[8:3]];
                pend = 1'b0;
            end else begin
                cnt--;
            end
        end else if (budget > 0 && o_fetch_req && !i_redirect && !i_rst) begin
            i_fetch_gnt = 1'b1;
            pend     = 1'b1;
            cnt      = lat;
            paddr    = o_fetch_addr;
            last_gnt = o_fetch_addr;
            budget--;
            ngnt++;
        end
    endtask

    task automatic cyc();
        mem_drive();
        @(negedge i_clk);
    endtask

    task automatic redirect(input logic [63:0] pc);
        i_redirect    = 1'b1;
        i_redirect_pc = pc;
        cyc();
        i_redirect    = 1'b0;
    endtask

    task automatic drain(input string name);
        int i;
        i = 0;
        while ((exp_q.size() != 0 || budget != 0 || pend) && i < 300) begin
            cyc();
            i++;
        end
        n_tests++;
        if (i >= 300) begin
            n_fail++;
            $display("FAIL drain_%s: %0d instructions still outstanding, required 0", name, exp_q.size());
            exp_q.delete();
        end
        repeat (4) cyc();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int g0;
        for (int i = 0; i < 64; i++) mem[i] = 64'h0;
        i_rst = 1'b1; i_fetch_gnt = 1'b0; i_fetch_rvalid = 1'b0; i_fetch_rdata = 64'h0;
        i_redirect = 1'b0; i_redirect_pc = 64'h0; i_stall = 1'b0;

        // Reset state
        repeat (2) @(negedge i_clk);
        chk("rst_fetch_req", 64'(o_fetch_req), 64'd0);
        chk("rst_valid", 64'(o_valid), 64'd0);
        chk("rst_fetch_addr", o_fetch_addr, 64'h0);
        chk("rst_pc0", o_pc0, 64'h0);
        i_rst = 1'b0;
        #1;
        chk("req_after_reset", 64'(o_fetch_req), 64'd1);

        // Plain 32-bit stream from the reset address
        for (int k = 0; k < 4; k++) begin
            mem[k] = 64'h00000013_00000013;
            exp_push(64'(8*k), 32'h00000013, 1'b0);
            exp_push(64'(8*k + 4), 32'h00000013, 1'b0);
        end
        budget = 4;
        drain("t1");

        // Four compressed-pattern parcels per packet
        mem[8] = 64'h0001_0001_0001_0001;
        mem[9] = 64'h0001_0001_0001_0001;
`ifdef WARP_RVC_EN
        for (int k = 0; k < 8; k++) exp_push(64'h40 + 64'(2*k), 32'h0001, 1'b1);
`else
        for (int k = 0; k < 4; k++) exp_push(64'h40 + 64'(4*k), 32'h00010001, 1'b0);
`endif
        redirect(64'h40);
        budget = 2;
        drain("t2");

        // 32-bit instruction straddling two packets
        mem[16] = 64'h0013_0001_0001_0001;
        mem[17] = 64'h0001_0001_0001_0000;
`ifdef WARP_RVC_EN
        exp_push(64'h80, 32'h0001, 1'b1);
        exp_push(64'h82, 32'h0001, 1'b1);
        exp_push(64'h84, 32'h0001, 1'b1);
        exp_push(64'h86, 32'h00000013, 1'b0);
        exp_push(64'h8a, 32'h0001, 1'b1);
        exp_push(64'h8c, 32'h0001, 1'b1);
        exp_push(64'h8e, 32'h0001, 1'b1);
`else
        exp_push(64'h80, 32'h00010001, 1'b0);
        exp_push(64'h84, 32'h00130001, 1'b0);
        exp_push(64'h88, 32'h00010000, 1'b0);
        exp_push(64'h8c, 32'h00010001, 1'b0);
`endif
        redirect(64'h80);
        budget = 2;
        drain("t3");

        // Redirect to 0x102 while a fetch is outstanding; the stale response must be dropped
        mem[18] = 64'hFFFF_FFFF_FFFF_FFFF;
        mem[32] = 64'h0000_0013_0001_FFFF;
        lat = 2;
        budget = 1;
        cyc();
        chk("t4_in_wait_req", 64'(o_fetch_req), 64'd0);
        lat = 0;
        budget = 1;
`ifdef WARP_RVC_EN
        exp_push(64'h102, 32'h0001, 1'b1);
        exp_push(64'h104, 32'h00000013, 1'b0);
`else
        exp_push(64'h100, 32'h0001FFFF, 1'b0);
        exp_push(64'h104, 32'h00000013, 1'b0);
`endif
        redirect(64'h102);
        drain("t4");
        chk("t4_refetch_addr", last_gnt, 64'h100);

        // Stall: request stops once the buffer holds more than DEPTH-4 parcels
        for (int k = 0; k < 3; k++) begin
            mem[40 + k] = 64'h00000033_00000013;
            exp_push(64'h140 + 64'(8*k), 32'h00000013, 1'b0);
            exp_push(64'h144 + 64'(8*k), 32'h00000033, 1'b0);
        end
        redirect(64'h140);
        lat = 0;
        budget = 3;
        i_stall = 1'b1;
        g0 = ngnt;
        for (int c = 0; c < 10; c++) begin
            cyc();
            if (c >= 4) begin
                chk("t5_stall_valid", 64'(o_valid), 64'd3);
                chk("t5_stall_pc0", o_pc0, 64'h140);
                chk("t5_stall_uinst1", 64'(o_uinst1), 64'h33);
            end
        end
        chk("t5_req_dropped", 64'(o_fetch_req), 64'd0);
        chk("t5_grants_in_stall", 64'(ngnt - g0), 64'd2);
        i_stall = 1'b0;
        drain("t5");

        // Redirect in the same cycle as a response
        mem[43] = 64'hFFFF_FFFF_FFFF_FFFF;
        mem[48] = 64'h00000013_00000013;
        lat = 0;
        budget = 1;
        cyc();
        i_redirect    = 1'b1;
        i_redirect_pc = 64'h180;
        cyc();
        i_redirect    = 1'b0;
        #1;
        chk("t6_buffer_empty", 64'(o_valid), 64'd0);
        chk("t6_state_req", 64'(o_fetch_req), 64'd1);
        chk("t6_fetch_addr", o_fetch_addr, 64'h180);
        exp_push(64'h180, 32'h00000013, 1'b0);
        exp_push(64'h184, 32'h00000013, 1'b0);
        budget = 1;
        drain("t6");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
